// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook countdown: FSM states,
// BCD digit limits and the MM:SS time record.
package microwave_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX       = 4'd9;
  localparam logic [BCD_W-1:0] SEC_TENS_WRAP = 4'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } cd_state_e;

  typedef struct packed {
    logic [BCD_W-1:0] min_tens;
    logic [BCD_W-1:0] min_units;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] sec_units;
  } bcd_time_t;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  function automatic logic time_is_zero(input bcd_time_t t);
    return (t == '0);
  endfunction

endpackage

// File: rtl/cook_countdown_if.sv
// Digit and control bundle between the keypad time-entry stage (master)
// and the cook countdown (slave).
interface cook_countdown_if;

  logic [3:0] second_min_in;
  logic [3:0] first_min_in;
  logic [3:0] second_sec_in;
  logic [3:0] first_sec_in;
  logic       load;
  logic       start;
  logic       pause;
  logic       cancel;
  logic       door_open;

  logic [3:0] second_min_out;
  logic [3:0] first_min_out;
  logic [3:0] second_sec_out;
  logic [3:0] first_sec_out;
  logic       running;
  logic       done;
  logic       beep;

  modport master (
    output second_min_in, first_min_in, second_sec_in, first_sec_in,
    output load, start, pause, cancel, door_open,
    input  second_min_out, first_min_out, second_sec_out, first_sec_out,
    input  running, done, beep
  );

  modport slave (
    input  second_min_in, first_min_in, second_sec_in, first_sec_in,
    input  load, start, pause, cancel, door_open,
    output second_min_out, first_min_out, second_sec_out, first_sec_out,
    output running, done, beep
  );

endinterface

// File: rtl/cook_countdown_bcd_digit_down.sv
// One BCD digit of the countdown borrow chain: wraps to WRAP when a borrow
// arrives at zero and passes the borrow on to the next digit.
module bcd_digit_down
  import microwave_pkg::*;
#(
  parameter logic [BCD_W-1:0] WRAP = BCD_MAX
) (
  input  logic [BCD_W-1:0] digit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_next,
  output logic             borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        digit_next = WRAP;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cook_countdown.sv
// Cook countdown: loads MM:SS from time entry, counts down once per clk_1s
// edge while running, pulses done at 00:00. Optional beeper under BEEP_EN.
//
//   state  | meaning
//   IDLE   | no time loaded (count 00:00)
//   ARMED  | nonzero time loaded, waiting for start
//   RUN    | counting down, magnetron enabled
//   PAUSED | suspended by pause or door, resumable with start
//   DONE   | reached 00:00, waiting for load or cancel
module cook_countdown
  import microwave_pkg::*;
#(
  parameter int unsigned BEEP_SECS = 3
) (
  input  logic             clk_1s,
  input  logic             reset,
  cook_countdown_if.slave  ifc
);

  cd_state_e state_q, state_d;
  bcd_time_t count_q, count_d;
  bcd_time_t load_val;
  logic      done_q, done_d;

  logic [BCD_W-1:0] dec_su, dec_st, dec_mu, dec_mt;
  logic             borrow_su, borrow_st, borrow_mu, borrow_mt;
  bcd_time_t        count_dec;
  logic             dec_underflow;

  bcd_digit_down #(.WRAP(BCD_MAX)) u_sec_units (
    .digit      (count_q.sec_units),
    .borrow_in  (1'b1),
    .digit_next (dec_su),
    .borrow_out (borrow_su)
  );

  bcd_digit_down #(.WRAP(SEC_TENS_WRAP)) u_sec_tens (
    .digit      (count_q.sec_tens),
    .borrow_in  (borrow_su),
    .digit_next (dec_st),
    .borrow_out (borrow_st)
  );

  bcd_digit_down #(.WRAP(BCD_MAX)) u_min_units (
    .digit      (count_q.min_units),
    .borrow_in  (borrow_st),
    .digit_next (dec_mu),
    .borrow_out (borrow_mu)
  );

  bcd_digit_down #(.WRAP(BCD_MAX)) u_min_tens (
    .digit      (count_q.min_tens),
    .borrow_in  (borrow_mu),
    .digit_next (dec_mt),
    .borrow_out (borrow_mt)
  );

  always_comb begin
    count_dec     = '{min_tens: dec_mt, min_units: dec_mu, sec_tens: dec_st, sec_units: dec_su};
    dec_underflow = borrow_mt;
    load_val      = '{min_tens:  bcd_clamp(ifc.second_min_in),
                      min_units: bcd_clamp(ifc.first_min_in),
                      sec_tens:  bcd_clamp(ifc.second_sec_in),
                      sec_units: bcd_clamp(ifc.first_sec_in)};
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (ifc.cancel) begin
      state_d = IDLE;
      count_d = '0;
    end else if (ifc.load && (state_q != RUN)) begin
      count_d = load_val;
      state_d = time_is_zero(load_val) ? IDLE : ARMED;
    end else begin
      case (state_q)
        ARMED, PAUSED: begin
          if (ifc.start && !ifc.door_open && !time_is_zero(count_q)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (ifc.door_open || ifc.pause) begin
            state_d = PAUSED;
          end else begin
            // Underflow cannot happen from a nonzero count; treat it as completion anyway.
            count_d = dec_underflow ? '0 : count_dec;
            if (dec_underflow || time_is_zero(count_dec)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_1s) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign ifc.second_min_out = count_q.min_tens;
  assign ifc.first_min_out  = count_q.min_units;
  assign ifc.second_sec_out = count_q.sec_tens;
  assign ifc.first_sec_out  = count_q.sec_units;
  assign ifc.running        = (state_q == RUN);
  assign ifc.done           = done_q;

`ifdef BEEP_EN
  localparam int BEEP_W = 8;

  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

  always_comb begin
    beep_cnt_d = (beep_cnt_q != '0) ? beep_cnt_q - 1'b1 : '0;
    if (ifc.cancel || (ifc.load && (state_q != RUN))) begin
      beep_cnt_d = '0;
    end else if (done_d) begin
      beep_cnt_d = BEEP_W'(BEEP_SECS);
    end
  end

  always_ff @(posedge clk_1s) begin
    if (reset) begin
      beep_cnt_q <= '0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign ifc.beep = (beep_cnt_q != '0);
`else
  logic unused_beep_cfg;
  assign unused_beep_cfg = (BEEP_SECS != 0);
  assign ifc.beep        = 1'b0;
`endif

endmodule

// File: tb/tb_cook_countdown.sv
// Bench for cook_countdown: directed scenarios then random control traffic,
// every edge compared against a decimal-arithmetic reference model.
module tb_cook_countdown;

  localparam int unsigned BEEP_SECS = 3;
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

  logic clk_1s = 1'b0;
  logic reset  = 1'b1;

  cook_countdown_if ifc ();

  cook_countdown #(.BEEP_SECS(BEEP_SECS)) dut (
    .clk_1s (clk_1s),
    .reset  (reset),
    .ifc    (ifc)
  );

  always #5 clk_1s = ~clk_1s;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: count held as the decimal number MMSS (0..9999).
  int m_val   = 0;
  int m_state = M_IDLE;
  int m_done  = 0;
  int m_beep  = 0;

  function automatic int clampd(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic model_edge();
    int s;
    int nv;
    if (reset) begin
      m_val = 0; m_state = M_IDLE; m_done = 0; m_beep = 0;
      return;
    end
    m_done = 0;
    if (m_beep > 0) m_beep = m_beep - 1;
    if (ifc.cancel) begin
      m_val = 0; m_state = M_IDLE; m_beep = 0;
    end else if (ifc.load && m_state != M_RUN) begin
      nv = clampd(ifc.second_min_in) * 1000 + clampd(ifc.first_min_in) * 100 +
           clampd(ifc.second_sec_in) * 10 + clampd(ifc.first_sec_in);
      m_val   = nv;
      m_state = (nv == 0) ? M_IDLE : M_ARMED;
      m_beep  = 0;
    end else if (m_state == M_ARMED || m_state == M_PAUSED) begin
      if (ifc.start && !ifc.door_open && m_val != 0) m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (ifc.door_open || ifc.pause) begin
        m_state = M_PAUSED;
      end else begin
        s = m_val % 100;
        m_val = (s > 0) ? m_val - 1 : m_val - 100 + 59;
        if (m_val == 0) begin
          m_state = M_DONE; m_done = 1; m_beep = int'(BEEP_SECS);
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_digits();
    logic [15:0] r;
    r[15:12] = 4'(m_val / 1000);
    r[11:8]  = 4'((m_val / 100) % 10);
    r[7:4]   = 4'((m_val / 10) % 10);
    r[3:0]   = 4'(m_val % 10);
    return r;
  endfunction

  function automatic logic [15:0] dut_digits();
    return {ifc.second_min_out, ifc.first_min_out, ifc.second_sec_out, ifc.first_sec_out};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("digits",  dut_digits(), exp_digits());
    check("running", 16'(ifc.running), 16'(m_state == M_RUN));
    check("done",    16'(ifc.done), 16'(m_done));
`ifdef BEEP_EN
    check("beep",    16'(ifc.beep), 16'(m_beep > 0));
`else
    check("beep",    16'(ifc.beep), 16'h0);
`endif
  endtask

  task automatic step();
    @(posedge clk_1s);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ctl(input logic ld, input logic st, input logic pa,
                     input logic ca, input logic dr);
    ifc.load = ld; ifc.start = st; ifc.pause = pa; ifc.cancel = ca; ifc.door_open = dr;
  endtask

  task automatic digits_in(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    ifc.second_min_in = a; ifc.first_min_in = b; ifc.second_sec_in = c; ifc.first_sec_in = d;
  endtask

  task automatic load_start(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    digits_in(a, b, c, d);
    ctl(1, 0, 0, 0, 0); step();
    ctl(0, 1, 0, 0, 0); step();
    ctl(0, 0, 0, 0, 0);
  endtask

  initial begin
    digits_in(0, 0, 0, 0);
    ctl(0, 0, 0, 0, 0);
    #2;

    reset = 1'b1; step();
    check("rst_digits", dut_digits(), 16'h0000);
    check("rst_running", 16'(ifc.running), 16'h0);
    reset = 1'b0;

    load_start(0, 0, 0, 3);
    check("run_0003", dut_digits(), 16'h0003);
    step(); check("dec_0002", dut_digits(), 16'h0002);
    check("done_early", 16'(ifc.done), 16'h0);
    step(); check("dec_0001", dut_digits(), 16'h0001);
    step(); check("dec_0000", dut_digits(), 16'h0000);
    check("done_pulse", 16'(ifc.done), 16'h1);
    check("run_fall", 16'(ifc.running), 16'h0);
    ctl(0, 1, 0, 0, 0); step();
    check("done_clear", 16'(ifc.done), 16'h0);
    check("done_start_ign", 16'(ifc.running), 16'h0);
    ctl(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();

    load_start(0, 1, 0, 0);
    step(); check("borrow_0059", dut_digits(), 16'h0059);
    ctl(0, 0, 0, 1, 0); step();

    load_start(1, 0, 0, 0);
    step(); check("borrow_0959", dut_digits(), 16'h0959);
    ctl(0, 0, 0, 1, 0); step();

    load_start(0, 0, 1, 0);
    ctl(0, 0, 0, 0, 1); step();
    check("door_hold", dut_digits(), 16'h0010);
    ctl(0, 1, 0, 0, 1); step();
    check("door_start_ign", 16'(ifc.running), 16'h0);
    ctl(0, 1, 0, 0, 0); step();
    check("resume_0010", dut_digits(), 16'h0010);
    ctl(0, 0, 0, 0, 0); step();
    check("resume_0009", dut_digits(), 16'h0009);
    ctl(0, 0, 1, 0, 0); step();
    check("pause_run", 16'(ifc.running), 16'h0);
    ctl(0, 0, 0, 1, 0); step();

    digits_in(0, 0, 0, 0);
    ctl(1, 0, 0, 0, 0); step();
    ctl(0, 1, 0, 0, 0); step();
    check("zero_start", 16'(ifc.running), 16'h0);
    digits_in(4'hC, 4'hC, 4'hC, 4'hC);
    ctl(1, 0, 0, 0, 0); step();
    check("clamp", dut_digits(), 16'h9999);
    ctl(0, 0, 1, 0, 0); step();
    ctl(0, 0, 0, 0, 0);

    load_start(0, 1, 7, 5);
    step(); check("tens_hi", dut_digits(), 16'h0174);
    digits_in(0, 0, 0, 1);
    ctl(1, 0, 0, 0, 0); step();
    check("load_in_run", dut_digits(), 16'h0173);
    ctl(0, 0, 0, 1, 0); step();

    load_start(0, 0, 0, 5);
    ctl(0, 1, 0, 1, 0); step();
    check("cancel_start", dut_digits(), 16'h0000);
    load_start(0, 0, 0, 5);
    step();
    reset = 1'b1; step();
    check("rst_mid_run", dut_digits(), 16'h0000);
    reset = 1'b0;

    load_start(0, 0, 0, 2);
    for (int i = 0; i < 6; i++) step();
    load_start(0, 0, 0, 1);
    step();
    ctl(0, 0, 0, 1, 0); step();
    check("beep_cancel", 16'(ifc.beep), 16'h0);
    ctl(0, 0, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      ifc.cancel = ($urandom_range(0, 99) < 3);
      ifc.load   = ($urandom_range(0, 99) < 10);
      ifc.start  = ($urandom_range(0, 99) < 30);
      ifc.pause  = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 6) ifc.door_open = ~ifc.door_open;
      ifc.second_min_in = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      ifc.first_min_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      ifc.second_sec_in = 4'($urandom_range(0, 15));
      ifc.first_sec_in  = 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
